mod_divider_arbiter: RTL and testbench

//  Shares one 26-stage pipelined divider (mod_divider: 26b dividend / 14b divisor -> 26b quotient, 14b remainder)

---
 rtl/mod_divider_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mod_divider_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_divider_arbiter.sv
// Round-robin front end sharing one 26-stage pipelined unsigned divider between N_REQ requesters.
// A tag shadow pipeline carries {vld, id, div0} beside the divider and drives the response bus.

module mod_divider #(
  parameter int DATA_W = 26,
  parameter int COEF_W = 14
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] dividend,
  input  logic [COEF_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [COEF_W-1:0] remainder
);
  // acc holds the unconsumed dividend bits on top and the quotient bits shifted in below
  logic [DATA_W-1:0] acc_p [DATA_W];
  logic [COEF_W-1:0] rem_p [DATA_W];
  logic [COEF_W-1:0] dvs_p [DATA_W-1];

  // One restoring step; the trial never exceeds 2*divisor-1, so the difference fits COEF_W bits.
  function automatic logic [COEF_W+DATA_W-1:0] div_step(
    input logic [COEF_W-1:0] rem,
    input logic [DATA_W-1:0] acc,
    input logic [COEF_W-1:0] dvs
  );
    logic [COEF_W:0]   trial;
    logic [COEF_W-1:0] diff;
    trial = {rem, acc[DATA_W-1]};
    diff  = trial[COEF_W-1:0] - dvs;
    if (trial >= {1'b0, dvs}) return {diff, acc[DATA_W-2:0], 1'b1};
    return {trial[COEF_W-1:0], acc[DATA_W-2:0], 1'b0};
  endfunction

  // stage 0: operands captured on the accepting edge, first quotient bit resolved
  always_ff @(posedge clk) begin
    {rem_p[0], acc_p[0]} <= div_step('0, dividend, divisor);
    dvs_p[0]             <= divisor;
  end

  // stages 1..DATA_W-1: one quotient bit per stage
  for (genvar s = 1; s < DATA_W; s++) begin : g_stage
    always_ff @(posedge clk) begin
      {rem_p[s], acc_p[s]} <= div_step(rem_p[s-1], acc_p[s-1], dvs_p[s-1]);
    end
    if (s < DATA_W - 1) begin : g_dvs
      always_ff @(posedge clk) dvs_p[s] <= dvs_p[s-1];
    end
  end

  assign quotient  = acc_p[DATA_W-1];
  assign remainder = rem_p[DATA_W-1];
endmodule

module mod_divider_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int MAX_OUT = 8,
  parameter int DIV_LAT = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*26-1:0] req_dividend,
  input  logic [N_REQ*14-1:0] req_divisor,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [25:0]        rsp_quotient,
  output logic [13:0]        rsp_remainder,
  output logic               rsp_div0,
  output logic               busy
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] credit_inc;
  logic [N_REQ-1:0] credit_dec;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  idx;
  logic [25:0]      div_dividend;
  logic [13:0]      div_divisor;
  logic [25:0]      div_quotient;
  logic [13:0]      div_remainder;

  logic [DIV_LAT-1:0] vld_p;
  logic [DIV_LAT-1:0] div0_p;
  logic [ID_W-1:0]    id_p [DIV_LAT];

  // Divide-by-zero results are pinned to all-ones quotient and zero remainder.
  function automatic logic [39:0] sat_div0(input logic [25:0] q, input logic [13:0] r,
                                           input logic div0);
    if (div0) return {26'h3FFFFFF, 14'h0};
    return {q, r};
  endfunction

  // Arbitration: registered credits only, scan starts just past the last winner
  always_comb begin
    eligible  = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT)) && !rst;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign req_ready    = grant_any ? (N_REQ'(1) << grant_id) : '0;
  assign div_dividend = grant_any ? req_dividend[int'(grant_id)*26 +: 26] : '0;
  assign div_divisor  = grant_any ? req_divisor[int'(grant_id)*14 +: 14] : '0;

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= ID_W'(N_REQ - 1);
    else if (grant_any) rr_ptr <= grant_id;
  end

  always_comb begin
    credit_inc = '0;
    credit_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      credit_inc[i] = grant_any && (grant_id == ID_W'(i));
      credit_dec[i] = rsp_valid && (rsp_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) cnt[i] <= '0;
      else if (credit_inc[i] && !credit_dec[i]) cnt[i] <= cnt[i] + 1'b1;
      else if (credit_dec[i] && !credit_inc[i]) cnt[i] <= cnt[i] - 1'b1;
      if (!rst) begin
        assert (!(credit_inc[i] && !credit_dec[i] && cnt[i] == CNT_W'(MAX_OUT)));
        assert (!(credit_dec[i] && !credit_inc[i] && cnt[i] == '0));
      end
    end
  end

  // Divider latency equals its dividend width, so DIV_LAT must stay at 26.
  mod_divider #(.DATA_W(26), .COEF_W(14)) u_div (
    .clk       (clk),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // shadow stage 0 loads with the issue; later stages march in lockstep with the divider
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else vld_p <= {vld_p[DIV_LAT-2:0], grant_any};
  end

  always_ff @(posedge clk) begin
    div0_p   <= {div0_p[DIV_LAT-2:0], (div_divisor == 14'h0)};
    id_p[0]  <= grant_id;
    for (int s = 1; s < DIV_LAT; s++) id_p[s] <= id_p[s-1];
  end

  // response: last shadow stage plus divider output
  assign rsp_valid = vld_p[DIV_LAT-1];
  assign rsp_id    = rsp_valid ? id_p[DIV_LAT-1] : '0;
  assign rsp_div0  = rsp_valid && div0_p[DIV_LAT-1];
  assign {rsp_quotient, rsp_remainder} = sat_div0(div_quotient, div_remainder, rsp_div0);
  assign busy      = |vld_p;
endmodule

// File: tb/tb_mod_divider_arbiter.sv
// Bench for mod_divider_arbiter: directed vector table, scoreboarded response checks,
// credit-limit sequence on a MAX_OUT=2 instance, and a mid-flight reset sequence.

module tb_mod_divider_arbiter;
  localparam int LAT = 26;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_valid2, req_ready2;
  logic [103:0] req_dividend, req_dividend2;
  logic [55:0]  req_divisor, req_divisor2;
  logic         rsp_valid, rsp_div0, busy, rsp_valid2, rsp_div02, busy2;
  logic [1:0]   rsp_id, rsp_id2;
  logic [25:0]  rsp_q, rsp_q2;
  logic [13:0]  rsp_r, rsp_r2;

  mod_divider_arbiter #(.N_REQ(4), .ID_W(2), .MAX_OUT(26), .DIV_LAT(26)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_q),
    .rsp_remainder(rsp_r), .rsp_div0(rsp_div0), .busy(busy));

  mod_divider_arbiter #(.N_REQ(4), .ID_W(2), .MAX_OUT(2), .DIV_LAT(26)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_dividend(req_dividend2), .req_divisor(req_divisor2),
    .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_quotient(rsp_q2),
    .rsp_remainder(rsp_r2), .rsp_div0(rsp_div02), .busy(busy2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [25:0] q;
    logic [13:0] r;
    logic        d0;
  } exp_t;

  typedef struct {
    int          id;
    logic [25:0] dvd;
    logic [13:0] dvs;
    logic [25:0] q;
    logic [13:0] r;
    logic        d0;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   acc_c[$];
  int   rsp_c[$];
  int   exp_ptr;
  int   exp_g;
  bit   bad_ready;

  function automatic void model(input logic [25:0] a, input logic [13:0] b,
                                output logic [25:0] q, output logic [13:0] r, output logic d0);
    if (b == 14'h0) begin
      q = 26'h3FFFFFF; r = 14'h0; d0 = 1'b1;
    end else begin
      q = a / b; r = 14'(a % b); d0 = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [25:0] q, input logic [13:0] r, input logic d0);
    sb.push_back('{cyc + LAT, 2'(id), q, r, d0});
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic issue_one(input int id, input logic [25:0] dvd, input logic [13:0] dvs,
                           input logic [25:0] eq, input logic [13:0] er, input logic ed0);
    bit done = 1'b0;
    req_dividend[26*id +: 26] = dvd;
    req_divisor[14*id +: 14]  = dvs;
    req_valid[id]             = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        push_exp(id, eq, er, ed0);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL accept_timeout: requester %0d got no grant, required one within 20 cycles", id);
    end
  endtask

  task automatic issue_rand(input int id);
    logic [25:0] a, q;
    logic [13:0] b, r;
    logic        d0;
    a = 26'($urandom);
    b = ($urandom_range(0, 5) == 0) ? 14'h0 : 14'($urandom);
    model(a, b, q, r, d0);
    issue_one(id, a, b, q, r, d0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor for the main instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d q=%0h r=%0h at cycle %0d, required no response",
                   rsp_id, rsp_q, rsp_r, cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.due || rsp_id !== e.id || rsp_div0 !== e.d0 || rsp_q !== e.q || rsp_r !== e.r) begin
            n_fail++;
            $display("FAIL rsp_data: got cyc=%0d id=%0d d0=%0b q=%0h r=%0h, required cyc=%0d id=%0d d0=%0b q=%0h r=%0h",
                     cyc, rsp_id, rsp_div0, rsp_q, rsp_r, e.due, e.id, e.d0, e.q, e.r);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_missing: got no rsp_valid at cycle %0d, required id=%0d q=%0h", cyc, e.id, e.q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 26'd1000,      14'd7,      26'd142,     14'd6,     1'b0};
    tbl[1] = '{2, 26'h3FFFFFF,   14'h3FFF,   26'h1000,    14'hFFF,   1'b0};
    tbl[2] = '{1, 26'd12345,     14'd0,      26'h3FFFFFF, 14'h0,     1'b1};
    tbl[3] = '{3, 26'd0,         14'd5,      26'd0,       14'd0,     1'b0};
    tbl[4] = '{0, 26'h2AAAAAA,   14'd1,      26'h2AAAAAA, 14'd0,     1'b0};
    tbl[5] = '{1, 26'd100,       14'd100,    26'd1,       14'd0,     1'b0};
    tbl[6] = '{2, 26'd99,        14'd100,    26'd0,       14'd99,    1'b0};
    tbl[7] = '{3, 26'h3FFFFFF,   14'd2,      26'h1FFFFFF, 14'd1,     1'b0};

    // reset state, with all requests raised to show grants are held off
    rst = 1'b1;
    req_valid = 4'hF;  req_valid2 = 4'hF;
    req_dividend = {4{26'd77}};  req_divisor = {4{14'd3}};
    req_dividend2 = {4{26'd77}}; req_divisor2 = {4{14'd3}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_id",    32'(rsp_id),    32'h0);
    check("reset_rsp_div0",  32'(rsp_div0),  32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    check("reset_req_ready2", 32'(req_ready2), 32'h0);
    @(posedge clk); #1;
    req_valid = 4'h0; req_valid2 = 4'h0;
    rst = 1'b0;

    // directed vectors, issued back to back
    for (int i = 0; i < 8; i++)
      issue_one(tbl[i].id, tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].d0);
    wait_drain();
    @(posedge clk); #1;

    // reset with five divides in flight
    issue_rand(0); issue_rand(1); issue_rand(2); issue_rand(3); issue_rand(0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("busy_in_flight", 32'(busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_reset", 32'(busy), 32'h0);
    check("rsp_after_reset",  32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    issue_one(0, 26'd1000, 14'd7, 26'd142, 14'd6, 1'b0);
    wait_drain();
    @(posedge clk); #1;

    // credit limit: MAX_OUT=2 instance, only requester 3 asking
    bad_ready = 1'b0;
    req_dividend2[78 +: 26] = 26'd500;
    req_divisor2[42 +: 14]  = 14'd3;
    req_valid2 = 4'b1000;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready2[3]) acc_c.push_back(cyc);
      if (req_ready2[2:0] != 3'b000) bad_ready = 1'b1;
      if (rsp_valid2) begin
        rsp_c.push_back(cyc);
        check("credit_rsp", {rsp_id2, rsp_div02, rsp_r2, 15'(rsp_q2)}, {2'd3, 1'b0, 14'd2, 15'd166});
      end
      @(posedge clk); #1;
    end
    req_valid2 = 4'h0;
    check("credit_ready_onehot", 32'(bad_ready), 32'h0);
    check("credit_accept_count", 32'(acc_c.size()), 32'd4);
    check("credit_rsp_count",    32'(rsp_c.size()), 32'd2);
    if (acc_c.size() >= 3 && rsp_c.size() >= 1) begin
      check("credit_second_accept", 32'(acc_c[1] - acc_c[0]), 32'd1);
      check("credit_first_rsp",     32'(rsp_c[0] - acc_c[0]), 32'd26);
      check("credit_reaccept",      32'(acc_c[2] - rsp_c[0]), 32'd1);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL credit_sequence: got %0d accepts / %0d responses, required at least 3 / 1",
               acc_c.size(), rsp_c.size());
    end

    // all four requesters streaming: rotating grants, one per cycle
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      req_dividend[26*i +: 26] = 26'($urandom);
      req_divisor[14*i +: 14]  = ($urandom_range(0, 6) == 0) ? 14'h0 : 14'($urandom);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 40; k++) begin
      logic [25:0] q;
      logic [13:0] r;
      logic        d0;
      @(negedge clk);
      exp_g = (exp_ptr + 1) % 4;
      check("stream_grant", 32'(req_ready), 32'(4'b0001 << exp_g));
      model(req_dividend[26*exp_g +: 26], req_divisor[14*exp_g +: 14], q, r, d0);
      push_exp(exp_g, q, r, d0);
      exp_ptr = exp_g;
      @(posedge clk); #1;
      req_dividend[26*exp_g +: 26] = 26'($urandom);
      req_divisor[14*exp_g +: 14]  = ($urandom_range(0, 6) == 0) ? 14'h0 : 14'($urandom_range(1, 16383));
    end
    req_valid = 4'h0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
